// File: rtl/alu_ctrl_mdu_if.sv
// Bundle between the ID/EX register and alu_ctrl_mdu: decode fields, M-op
// operands and handshake, plus the decoded control and iterative-unit results.
interface alu_ctrl_mdu_if #(
    parameter int XLEN = 32
);
    logic [2:0]      funct3_i;
    logic [6:0]      funct7_i;
    logic [1:0]      ALUOp_i;
    logic            start_i;
    logic            kill_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic [3:0]      ALUCtrl_o;
    logic            is_mdu_o;
    logic            illegal_o;
    logic            mdu_busy_o;
    logic            mdu_done_o;
    logic [XLEN-1:0] mdu_result_o;

    modport master (
        output funct3_i, funct7_i, ALUOp_i, start_i, kill_i, src1_i, src2_i,
        input  ALUCtrl_o, is_mdu_o, illegal_o, mdu_busy_o, mdu_done_o, mdu_result_o
    );

    modport slave (
        input  funct3_i, funct7_i, ALUOp_i, start_i, kill_i, src1_i, src2_i,
        output ALUCtrl_o, is_mdu_o, illegal_o, mdu_busy_o, mdu_done_o, mdu_result_o
    );
endinterface

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with RV32M/RV64M decode and an iterative radix-2
// multiply/divide unit (shift-add multiply, restoring divide).
module alu_ctrl_mdu #(
    parameter int XLEN = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_ctrl_mdu_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]      op_reg;
    logic [XLEN-1:0] hi_reg, lo_reg, b_reg, a_raw_reg, result_reg;
    logic            neg_reg, div0_reg;

    logic [3:0]      alu_ctrl;
    logic            is_mdu, illegal;
    logic            busy, done;

    // ---------------- combinational decode ----------------
    always_comb begin
        alu_ctrl = 4'b1111;
        illegal  = 1'b1;
        is_mdu   = 1'b0;
        case (bus.ALUOp_i)
            2'b00: begin
                alu_ctrl = 4'b0010;
                illegal  = 1'b0;
            end
            2'b01: begin
                case (bus.funct3_i)
                    3'b000:  begin alu_ctrl = 4'b0110; illegal = 1'b0; end
                    3'b001:  begin alu_ctrl = 4'b1001; illegal = 1'b0; end
                    default: ;
                endcase
            end
            2'b11: begin
                illegal = 1'b0;
                case (bus.funct3_i)
                    3'b000:  alu_ctrl = 4'b0010;
                    3'b110:  alu_ctrl = 4'b0001;
                    3'b111:  alu_ctrl = 4'b0000;
                    3'b100:  alu_ctrl = 4'b0111;
                    3'b001:  alu_ctrl = 4'b0100;
                    3'b101:  alu_ctrl = 4'b0101;
                    default: illegal  = 1'b1;
                endcase
            end
            default: begin
                if (bus.funct7_i == 7'b0000000) begin
                    illegal = 1'b0;
                    case (bus.funct3_i)
                        3'b000:  alu_ctrl = 4'b0010;
                        3'b110:  alu_ctrl = 4'b0001;
                        3'b111:  alu_ctrl = 4'b0000;
                        3'b100:  alu_ctrl = 4'b0111;
                        default: illegal  = 1'b1;
                    endcase
                end else if (bus.funct7_i == 7'b0100000 && bus.funct3_i == 3'b000) begin
                    alu_ctrl = 4'b0011;
                    illegal  = 1'b0;
                end else if (bus.funct7_i == 7'b0000001) begin
                    alu_ctrl = 4'b1000;
                    illegal  = 1'b0;
                    is_mdu   = 1'b1;
                end
            end
        endcase
    end

    // ---------------- launch: operand magnitudes and result sign ----------------
    logic            signed_a, signed_b, a_neg, b_neg, launch, launch_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        signed_a   = bus.funct3_i[2] ? ~bus.funct3_i[0] : ~(bus.funct3_i[1] & bus.funct3_i[0]);
        signed_b   = bus.funct3_i[2] ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
        a_neg      = signed_a & bus.src1_i[XLEN-1];
        b_neg      = signed_b & bus.src2_i[XLEN-1];
        a_mag      = a_neg ? -bus.src1_i : bus.src1_i;
        b_mag      = b_neg ? -bus.src2_i : bus.src2_i;
        // Remainders take the dividend's sign; everything else the product/quotient sign.
        launch_neg = (bus.funct3_i[2] & bus.funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
        launch     = (state_reg == S_IDLE) && bus.start_i && is_mdu && !bus.kill_i;
    end

    // ---------------- one radix-2 step ----------------
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   step_hi, step_lo, final_res;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic              last_step, div_fits;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? b_reg : '0)};
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_reg};
        div_fits  = ~div_diff[XLEN];
        if (op_reg[2]) begin
            step_hi = div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {lo_reg[XLEN-2:0], div_fits};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
        last_step = (cnt_reg == CNT_W'(XLEN - 1));

        prod     = {step_hi, step_lo};
        prod_fix = neg_reg ? -prod : prod;
        case (op_reg)
            3'b000:         final_res = prod_fix[XLEN-1:0];
            3'b100, 3'b101: final_res = div0_reg ? '1 : (neg_reg ? -step_lo : step_lo);
            3'b110, 3'b111: final_res = div0_reg ? a_raw_reg : (neg_reg ? -step_hi : step_hi);
            default:        final_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (bus.kill_i) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  if (launch) state_next = S_CALC;
                S_CALC:  if (last_step) state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_reg != S_IDLE);
        done = (state_reg == S_DONE);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_reg    <= '0;
            op_reg     <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            b_reg      <= '0;
            a_raw_reg  <= '0;
            neg_reg    <= 1'b0;
            div0_reg   <= 1'b0;
            result_reg <= '0;
        end else if (bus.kill_i) begin
            cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (launch) begin
                    op_reg    <= bus.funct3_i;
                    hi_reg    <= '0;
                    lo_reg    <= a_mag;
                    b_reg     <= b_mag;
                    a_raw_reg <= bus.src1_i;
                    neg_reg   <= launch_neg;
                    div0_reg  <= (bus.src2_i == '0);
                    cnt_reg   <= '0;
                end
                S_CALC: begin
                    hi_reg <= step_hi;
                    lo_reg <= step_lo;
                    if (last_step) begin
                        cnt_reg    <= '0;
                        result_reg <= final_res;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ALUCtrl_o    = alu_ctrl;
    assign bus.is_mdu_o     = is_mdu;
    assign bus.illegal_o    = illegal;
    assign bus.mdu_busy_o   = busy;
    assign bus.mdu_done_o   = done;
    assign bus.mdu_result_o = result_reg;
endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
- Parametrised successor of the single-cycle ALU control decoder.
- Decodes ALUOp/funct3/funct7 into the 4-bit ALU control code, adds RV32M/RV64M decode, and contains an iterative multiply/divide unit with a start/done handshake.
- Sits between the ID/EX pipeline register and the ALU/EX stage. The hazard unit stalls the pipeline while mdu_busy_o is high.

Parameters:
- XLEN, 32: operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1: iteration counter width; derived, never overridden.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- funct3_i  input  3  instruction funct3
- funct7_i  input  7  instruction funct7
- ALUOp_i  input  2  main-control ALU class
- start_i  input  1  one-cycle request to launch an M operation
- kill_i  input  1  synchronous abort (pipeline flush)
- src1_i  input  XLEN  rs1 operand
- src2_i  input  XLEN  rs2 operand
- ALUCtrl_o  output  4  ALU control code (combinational)
- is_mdu_o  output  1  decoded instruction is an M-extension op (combinational)
- illegal_o  output  1  undefined ALUOp/funct combination (combinational)
- mdu_busy_o  output  1  iterative unit occupied
- mdu_done_o  output  1  one-cycle pulse, result valid
- mdu_result_o  output  XLEN  M-op result, held until next start

Behaviour:
- Decode is purely combinational. Every path assigns all outputs; the default is ALUCtrl_o=4'b1111 with illegal_o=1. No latches.
  - ALUOp 00: 0010.
  - ALUOp 01, funct3 000: 0110. funct3 001: 1001.
  - ALUOp 11, funct3 000/110/111/100/001/101: 0010/0001/0000/0111/0100/0101 respectively.
  - ALUOp 10, funct7 0000000, funct3 000/110/111/100: 0010/0001/0000/0111.
  - ALUOp 10, funct7 0100000, funct3 000: 0011.
  - ALUOp 10, funct7 0000001: is_mdu_o=1, ALUCtrl_o=4'b1000, illegal_o=0. funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (000..111).
- FSM states: IDLE, CALC, DONE.
  - IDLE→CALC: on a clock edge with start_i=1, is_mdu_o=1 and kill_i=0. funct3, src1_i and src2_i are latched. Operands are converted to magnitudes per signedness, and the result sign and special-case flags are recorded.
  - IDLE ignores start_i when is_mdu_o=0.
  - CALC: one radix-2 step per cycle, XLEN cycles, counted by the iteration counter.
    - Multiply: shift-add over a 2*XLEN product register.
    - Divide: restoring divide, one quotient bit per cycle.
  - CALC→DONE after the XLEN-th step. The final sign correction is applied on entry to DONE.
  - DONE: mdu_done_o=1 for exactly one cycle, then →IDLE.
- Latency: start sampled at edge N → mdu_done_o high in cycle N+XLEN+1 (33 cycles for XLEN=32).
- mdu_busy_o=1 in CALC and DONE. start_i while busy is ignored; no queueing.
- Results:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product, signed×signed / signed×unsigned / unsigned×unsigned.
  - DIV/DIVU: quotient, truncated toward zero.
  - REM/REMU: remainder, with the sign of the dividend.
- Special cases use the same full latency; there is no early-out.
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder = 0.
- kill_i=1 in any state: next state IDLE, no done pulse, mdu_result_o unchanged. kill_i has priority over start_i.
- Reset (rst_i low, any time, including mid-CALC): state IDLE, counter 0, mdu_busy_o=0, mdu_done_o=0, mdu_result_o=0, all internal registers 0.
- mdu_result_o updates only on the CALC→DONE transition.

Test Plan:
- Decode sweep: all 4×8×{0000000,0100000,0000001,other} combinations → ALUCtrl_o matches the table. For example, ALUOp=10, funct3=000, funct7=0100000 → 0011; ALUOp=10, funct7=1111111 → 1111 with illegal_o=1.
- MUL/MULH: src1=0xFFFFFFFF, src2=0x00000002, funct3=000 → result 0xFFFFFFFE. With funct3=001 → 0xFFFFFFFF. With funct3=011 → 0x00000001. Done pulse at exactly start+33 in every case.
- DIV/REM signed: src1=0xFFFFFFF9 (−7), src2=2 → DIV 0xFFFFFFFD (−3), REM 0xFFFFFFFF (−1). DIVU same operands → 0x7FFFFFFC.
- Special cases: DIV x/0 with x=0x12345678 → 0xFFFFFFFF, REM → 0x12345678. DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Handshake: second start_i at start+5 ignored; kill_i at start+10 → no done pulse, busy drops the next cycle, and the prior result is retained; a new start immediately after the kill completes normally.
- Reset: deassert-then-assert rst_i mid-CALC → all outputs 0 asynchronously, FSM IDLE; operation after release correct. XLEN=64 regression: MULHU 0xFFFF…F × 0xFFFF…F → 0xFFFF…FE, done at start+65.
